// File: rtl/ov7670_seq_pkg.sv
// Shared encodings, debug decode and default timing for the OV7670 bring-up sequencer.
package ov7670_seq_pkg;

    // 3-bit state encodings, also exported on state_o for the ILA
    localparam logic [2:0] ST_PWDN      = 3'd0;
    localparam logic [2:0] ST_CAM_RST   = 3'd1;
    localparam logic [2:0] ST_WAKE      = 3'd2;
    localparam logic [2:0] ST_CFG_START = 3'd3;
    localparam logic [2:0] ST_CFG_WAIT  = 3'd4;
    localparam logic [2:0] ST_RUN       = 3'd5;
    localparam logic [2:0] ST_FAULT     = 3'd6;

    typedef enum logic [2:0] {
        S_PWDN      = ST_PWDN,
        S_CAM_RST   = ST_CAM_RST,
        S_WAKE      = ST_WAKE,
        S_CFG_START = ST_CFG_START,
        S_CFG_WAIT  = ST_CFG_WAIT,
        S_RUN       = ST_RUN,
        S_FAULT     = ST_FAULT
    } seq_state_e;

    // Timer covers the widest timing constant (the config timeout)
    localparam int TMR_W = 24;

    // Defaults for a 24 MHz pclk
    localparam logic [15:0] DEF_T_PWDN_CYC      = 16'd2400;      // 100 us
    localparam logic [15:0] DEF_T_RST_CYC       = 16'd240;       // 10 us
    localparam logic [19:0] DEF_T_WAKE_CYC      = 20'd25000;     // ~1.04 ms
    localparam logic [23:0] DEF_CFG_TIMEOUT_CYC = 24'd2500000;   // ~104 ms
    localparam logic [1:0]  DEF_MAX_RETRY       = 2'd3;

    // Debug encoding of a state for state_o
    function automatic logic [2:0] state_code(input seq_state_e s);
        return 3'(s);
    endfunction

endpackage

// File: rtl/ov7670_reset_seq_timer.sv
// Shared interval timer: up-counter with clear, saturation and terminal-count compare.
module seq_timer
    import ov7670_seq_pkg::*;
#(
    parameter int W = TMR_W
) (
    input  logic         pclk,
    input  logic         reset,
    input  logic         clr,
    input  logic [W-1:0] tc_val,
    output logic         tc_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Next count: clear on request, otherwise count up and hold at all-ones
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can leave it unassigned and infer a latch.
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (count_q != '1) begin
            count_d = count_q + 1'b1;
        end
    end

    // Count register with synchronous reset
    always_ff @(posedge pclk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tc_o = (count_q == tc_val);

endmodule

// File: rtl/ov7670_reset_seq.sv
// OV7670 power-up sequencer: PWDN/RESET pin timing, SCCB config handshake with
// bounded retries, and ordered release of the display and capture resets.
module ov7670_reset_seq
    import ov7670_seq_pkg::*;
#(
    parameter logic [15:0] T_PWDN_CYC      = DEF_T_PWDN_CYC,
    parameter logic [15:0] T_RST_CYC       = DEF_T_RST_CYC,
    parameter logic [19:0] T_WAKE_CYC      = DEF_T_WAKE_CYC,
    parameter logic [23:0] CFG_TIMEOUT_CYC = DEF_CFG_TIMEOUT_CYC,
    parameter logic [1:0]  MAX_RETRY       = DEF_MAX_RETRY
) (
    input  logic       pclk,
    input  logic       reset,
    input  logic       soft_rst_req,
    input  logic       cfg_done,
    input  logic       cfg_err,
    output logic       cam_pwdn,
    output logic       cam_rst_n,
    output logic       cfg_start,
    output logic       display_rst,
    output logic       capture_rst,
    output logic       ready,
    output logic       fault,
    output logic [2:0] state_o
);

    seq_state_e state_q, state_d;
    logic [1:0] retry_cnt_q, retry_cnt_d;
    logic [1:0] retry_inc;
    logic       disp_released_q, disp_released_d;

    logic cam_pwdn_q, cam_pwdn_d;
    logic cam_rst_n_q, cam_rst_n_d;
    logic cfg_start_q, cfg_start_d;
    logic display_rst_q, display_rst_d;
    logic capture_rst_q, capture_rst_d;
    logic ready_q, ready_d;
    logic fault_q, fault_d;

    logic             tmr_clr;
    logic             tmr_tc;
    logic [TMR_W-1:0] tmr_tc_val;

    // Terminal count for whichever timed state is current; exit fires at N-1
    always_comb begin
        tmr_tc_val = '1;
        case (state_q)
            S_PWDN:     tmr_tc_val = TMR_W'(T_PWDN_CYC) - TMR_W'(1);
            S_CAM_RST:  tmr_tc_val = TMR_W'(T_RST_CYC) - TMR_W'(1);
            S_WAKE:     tmr_tc_val = TMR_W'(T_WAKE_CYC) - TMR_W'(1);
            S_CFG_WAIT: tmr_tc_val = TMR_W'(CFG_TIMEOUT_CYC) - TMR_W'(1);
            default:    tmr_tc_val = '1;
        endcase
    end

    // Timer restarts on every state entry and on a soft restart (which may re-enter PWDN from PWDN)
    assign tmr_clr = soft_rst_req || (state_d != state_q);

    seq_timer #(.W(TMR_W)) u_timer (
        .pclk   (pclk),
        .reset  (reset),
        .clr    (tmr_clr),
        .tc_val (tmr_tc_val),
        .tc_o   (tmr_tc)
    );

    // Next-state and retry bookkeeping; soft restart overrides everything below reset
    always_comb begin
        state_d     = state_q;
        retry_cnt_d = retry_cnt_q;
        retry_inc   = retry_cnt_q + 2'd1;
        case (state_q)
            S_PWDN:      if (tmr_tc) state_d = S_CAM_RST;
            S_CAM_RST:   if (tmr_tc) state_d = S_WAKE;
            S_WAKE:      if (tmr_tc) state_d = S_CFG_START;
            S_CFG_START: state_d = S_CFG_WAIT;
            S_CFG_WAIT: begin
                // Error and timeout both outrank a simultaneous cfg_done
                if (cfg_err || tmr_tc) begin
                    retry_cnt_d = retry_inc;
                    state_d     = (retry_inc == MAX_RETRY) ? S_FAULT : S_PWDN;
                end else if (cfg_done) begin
                    state_d = S_RUN;
                end
            end
            S_RUN:       state_d = S_RUN;
            S_FAULT:     state_d = S_FAULT;
            default:     state_d = S_PWDN;
        endcase
        if (soft_rst_req) begin
            state_d     = S_PWDN;
            retry_cnt_d = '0;
        end
    end

    // Sticky display release: set on entering WAKE, survives retries, cleared only by a restart
    always_comb begin
        disp_released_d = disp_released_q || (state_d == S_WAKE);
        if (soft_rst_req) begin
            disp_released_d = 1'b0;
        end
    end

    // Output decode from next state so pins move on the same edge as state_o
    always_comb begin
        cam_pwdn_d    = (state_d == S_PWDN) || (state_d == S_FAULT);
        cam_rst_n_d   = (state_d == S_WAKE) || (state_d == S_CFG_START) ||
                        (state_d == S_CFG_WAIT) || (state_d == S_RUN);
        cfg_start_d   = (state_d == S_CFG_START);
        display_rst_d = !disp_released_d;
        capture_rst_d = (state_d != S_RUN);
        ready_d       = (state_d == S_RUN);
        fault_d       = (state_d == S_FAULT);
    end

    // State, retry count, release flag and registered outputs
    always_ff @(posedge pclk) begin
        if (reset) begin
            state_q         <= S_PWDN;
            retry_cnt_q     <= '0;
            disp_released_q <= 1'b0;
            cam_pwdn_q      <= 1'b1;
            cam_rst_n_q     <= 1'b0;
            cfg_start_q     <= 1'b0;
            display_rst_q   <= 1'b1;
            capture_rst_q   <= 1'b1;
            ready_q         <= 1'b0;
            fault_q         <= 1'b0;
        end else begin
            state_q         <= state_d;
            retry_cnt_q     <= retry_cnt_d;
            disp_released_q <= disp_released_d;
            cam_pwdn_q      <= cam_pwdn_d;
            cam_rst_n_q     <= cam_rst_n_d;
            cfg_start_q     <= cfg_start_d;
            display_rst_q   <= display_rst_d;
            capture_rst_q   <= capture_rst_d;
            ready_q         <= ready_d;
            fault_q         <= fault_d;
        end
    end

    assign cam_pwdn    = cam_pwdn_q;
    assign cam_rst_n   = cam_rst_n_q;
    assign cfg_start   = cfg_start_q;
    assign display_rst = display_rst_q;
    assign capture_rst = capture_rst_q;
    assign ready       = ready_q;
    assign fault       = fault_q;
    assign state_o     = state_code(state_q);

endmodule
